// File: rtl/aes_chk_pkg.sv
// -----------------------------------------------------------------------------
// aes_chk_pkg
// Shared definitions for the AES stream checker:
//   - AES_BLOCK_W : default compared block width (one AES block)
//   - chk_state_t : checker FSM state encoding (IDLE / RUN / DONE / TOUT)
//   - is_terminal : true for the states that hold until reset
// -----------------------------------------------------------------------------
package aes_chk_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [1:0] chk_state_t;

    localparam chk_state_t ST_IDLE = 2'd0;
    localparam chk_state_t ST_RUN  = 2'd1;
    localparam chk_state_t ST_DONE = 2'd2;
    localparam chk_state_t ST_TOUT = 2'd3;

    // DONE and TOUT both freeze the checker until the next reset.
    function automatic logic is_terminal(input chk_state_t s);
        return (s == ST_DONE) || (s == ST_TOUT);
    endfunction

endpackage

// File: rtl/aes_chk_delay_line.sv
// -----------------------------------------------------------------------------
// aes_chk_delay_line
// Fixed-depth shift register carrying a valid flag alongside a data word.
// A word presented on an edge appears on the outputs DEPTH edges later
// (it is visible combinationally on out_* during the cycle before that edge,
// so the consumer samples it together with whatever arrives on that edge).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, clears every stage
//   freeze    in   when high, every stage holds its contents
//   in_valid  in   valid flag entering stage 0
//   in_data   in   W-bit data entering stage 0
//   out_valid out  valid flag leaving the last stage
//   out_data  out  W-bit data leaving the last stage
// -----------------------------------------------------------------------------
module aes_chk_delay_line #(
    parameter int W     = 128,
    parameter int DEPTH = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // chain_*[k] is the input of stage k; chain_*[DEPTH] is the line output.
    logic         chain_valid [DEPTH+1];
    logic [W-1:0] chain_data  [DEPTH+1];

    assign chain_valid[0] = in_valid;
    assign chain_data[0]  = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic         valid_q;
            logic         valid_d;
            logic [W-1:0] data_q;
            logic [W-1:0] data_d;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (!freeze) begin
                    valid_d = chain_valid[gi];
                    data_d  = chain_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign chain_valid[gi+1] = valid_q;
            assign chain_data[gi+1]  = data_q;
        end
    endgenerate

    assign out_valid = chain_valid[DEPTH];
    assign out_data  = chain_data[DEPTH];

endmodule

// File: rtl/aes_stream_checker.sv
// -----------------------------------------------------------------------------
// aes_stream_checker
// Self-checking monitor for a pipelined AES core. Each issued block's expected
// ciphertext is delayed by the core latency and compared with the core output.
// Counts matches/mismatches, captures the first mismatch, runs an idle
// watchdog and raises a verdict after NUM_VEC comparisons.
//
// Optional feature macro: AES_CHK_DISPLAY_EN
//   defined   -> simulation messages on mismatch, and a verdict message
//                followed by $finish on entry to DONE or TOUT
//   undefined -> no system tasks; port behaviour is identical
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   in_valid         in   a block was issued to the core on this edge
//   in_expect        in   expected core output for that block
//   dut_out          in   core output
//   pass_cnt         out  matching comparisons (saturating)
//   fail_cnt         out  mismatching comparisons (saturating)
//   first_fail_idx   out  0-based comparison index of the first mismatch
//   first_fail_data  out  dut_out captured at the first mismatch
//   done             out  run finished (complete or timeout)
//   pass             out  done, no mismatches and no timeout
//   timeout          out  watchdog fired
// -----------------------------------------------------------------------------
module aes_stream_checker
    import aes_chk_pkg::*;
#(
    parameter int DATA_W  = AES_BLOCK_W,
    parameter int LATENCY = 21,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_expect,
    input  logic [DATA_W-1:0] dut_out,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data,
    output logic              done,
    output logic              pass,
    output logic              timeout
);

    localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  NUM_VEC_C = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ---------------------------------------------------------------- state
    chk_state_t          state_q, state_d;
    logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]    chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]    first_fail_idx_q, first_fail_idx_d;
    logic [DATA_W-1:0]   first_fail_data_q, first_fail_data_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;

    // ---------------------------------------------------------- delay line
    logic                frozen;
    logic                dl_valid;
    logic [DATA_W-1:0]   dl_expect;
    logic                issue;
    logic                cmp_fire;
    logic                cmp_match;

    assign frozen    = is_terminal(state_q);
    assign issue     = in_valid && !frozen;
    // Entries still in flight when the run ends are frozen and never compared.
    assign cmp_fire  = dl_valid && !frozen;
    assign cmp_match = (dl_expect == dut_out);

    aes_chk_delay_line #(
        .W     (DATA_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (frozen),
        .in_valid  (issue),
        .in_data   (in_expect),
        .out_valid (dl_valid),
        .out_data  (dl_expect)
    );

    // -------------------------------------------------------- next state
    always_comb begin
        state_d           = state_q;
        pass_cnt_d        = pass_cnt_q;
        fail_cnt_d        = fail_cnt_q;
        chk_cnt_d         = chk_cnt_q;
        first_fail_idx_d  = first_fail_idx_q;
        first_fail_data_d = first_fail_data_q;
        idle_cnt_d        = idle_cnt_q;
        done_d            = done_q;
        pass_d            = pass_q;
        timeout_d         = timeout_q;

        if (cmp_fire) begin
            chk_cnt_d = sat_inc(chk_cnt_q);
            if (cmp_match) begin
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                // fail_cnt never wraps, so zero means no earlier mismatch.
                if (fail_cnt_q == '0) begin
                    first_fail_idx_d  = chk_cnt_q;
                    first_fail_data_d = dut_out;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue || cmp_fire) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != TIMEOUT_C) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end

                if (cmp_fire && (chk_cnt_d == NUM_VEC_C)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_cnt_d == '0);
                end else if (idle_cnt_d == TIMEOUT_C) begin
                    state_d   = ST_TOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: begin
                // DONE / TOUT hold everything until reset.
            end
        endcase
    end

    // ------------------------------------------------------------ flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            pass_cnt_q        <= '0;
            fail_cnt_q        <= '0;
            chk_cnt_q         <= '0;
            first_fail_idx_q  <= '0;
            first_fail_data_q <= '0;
            idle_cnt_q        <= '0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            pass_cnt_q        <= pass_cnt_d;
            fail_cnt_q        <= fail_cnt_d;
            chk_cnt_q         <= chk_cnt_d;
            first_fail_idx_q  <= first_fail_idx_d;
            first_fail_data_q <= first_fail_data_d;
            idle_cnt_q        <= idle_cnt_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            timeout_q         <= timeout_d;
        end
    end

    assign pass_cnt        = pass_cnt_q;
    assign fail_cnt        = fail_cnt_q;
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_data = first_fail_data_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;

`ifdef AES_CHK_DISPLAY_EN
    // Simulation-only reporting; evaluated on the same edge the flops update.
    always @(posedge clk) begin
        if (rst_n) begin
            if (cmp_fire && !cmp_match) begin
                $display("aes_stream_checker: mismatch idx=%0d expected=%h actual=%h",
                         chk_cnt_q, dl_expect, dut_out);
            end
            if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
                if (pass_d) begin
                    $display("Good.");
                end else begin
                    $display("Bad. fail_cnt=%0d", fail_cnt_d);
                end
                $finish;
            end
            if ((state_q == ST_RUN) && (state_d == ST_TOUT)) begin
                $display("Timeout.");
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_checker
// Directed bench for aes_stream_checker. Three checker instances cover the
// parameter sets exercised: u_a (LATENCY 21, NUM_VEC 1), u_b (LATENCY 21,
// NUM_VEC 16, TIMEOUT 64) and u_c (LATENCY 1, NUM_VEC 4). The bench plays the
// role of the AES core by presenting each expected block on dut_out exactly
// LATENCY edges after it was issued (optionally corrupted).
// -----------------------------------------------------------------------------
module tb_aes_stream_checker;

    localparam int DW = 128;
    localparam int CW = 16;
    localparam logic [DW-1:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic          a_in_valid;
    logic [DW-1:0] a_in_expect, a_dut_out, a_ffd;
    logic [CW-1:0] a_pass_cnt, a_fail_cnt, a_ffi;
    logic          a_done, a_pass, a_timeout;
    // instance B
    logic          b_in_valid;
    logic [DW-1:0] b_in_expect, b_dut_out, b_ffd;
    logic [CW-1:0] b_pass_cnt, b_fail_cnt, b_ffi;
    logic          b_done, b_pass, b_timeout;
    // instance C
    logic          c_in_valid;
    logic [DW-1:0] c_in_expect, c_dut_out, c_ffd;
    logic [CW-1:0] c_pass_cnt, c_fail_cnt, c_ffi;
    logic          c_done, c_pass, c_timeout;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] vec [16];

    aes_stream_checker #(.DATA_W(DW), .LATENCY(21), .NUM_VEC(1), .CNT_W(CW), .TIMEOUT(1024)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_expect(a_in_expect),
        .dut_out(a_dut_out), .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt),
        .first_fail_idx(a_ffi), .first_fail_data(a_ffd), .done(a_done),
        .pass(a_pass), .timeout(a_timeout));

    aes_stream_checker #(.DATA_W(DW), .LATENCY(21), .NUM_VEC(16), .CNT_W(CW), .TIMEOUT(64)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_expect(b_in_expect),
        .dut_out(b_dut_out), .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt),
        .first_fail_idx(b_ffi), .first_fail_data(b_ffd), .done(b_done),
        .pass(b_pass), .timeout(b_timeout));

    aes_stream_checker #(.DATA_W(DW), .LATENCY(1), .NUM_VEC(4), .CNT_W(CW), .TIMEOUT(64)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_expect(c_in_expect),
        .dut_out(c_dut_out), .pass_cnt(c_pass_cnt), .fail_cnt(c_fail_cnt),
        .first_fail_idx(c_ffi), .first_fail_data(c_ffd), .done(c_done),
        .pass(c_pass), .timeout(c_timeout));

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        a_in_valid = 1'b0; a_in_expect = '0; a_dut_out = '0;
        b_in_valid = 1'b0; b_in_expect = '0; b_dut_out = '0;
        c_in_valid = 1'b0; c_in_expect = '0; c_dut_out = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({b_pass_cnt, b_fail_cnt, b_ffi} !== '0) begin
            n_err++;
            $display("FAIL reset_counts: got %h, want 0", {b_pass_cnt, b_fail_cnt, b_ffi});
        end
        n_vec++;
        if (b_ffd !== '0) begin
            n_err++;
            $display("FAIL reset_ffd: got %h, want 0", b_ffd);
        end
        n_vec++;
        if ({a_done, b_done, c_done, b_pass, b_timeout} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 00000", {a_done, b_done, c_done, b_pass, b_timeout});
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset: pass_cnt=%0d done=%0d", b_pass_cnt, b_done);
    endtask

    task automatic test_fips;
        do_reset();
        a_in_valid  = 1'b1;
        a_in_expect = FIPS_CT;
        tick();                         // issue edge T
        a_in_valid  = 1'b0;
        a_in_expect = '0;
        for (int c = 1; c <= 21; c++) begin
            a_dut_out = (c == 21) ? FIPS_CT : '0;
            tick();
            if (c == 20) begin
                n_vec++;
                if ({a_done, a_pass_cnt} !== {1'b0, 16'd0}) begin
                    n_err++;
                    $display("FIPS early_done: got done=%0d pass_cnt=%0d, want 0/0 FAIL", a_done, a_pass_cnt);
                end
            end
        end
        n_vec++;
        if ({a_done, a_pass, a_timeout} !== 3'b110) begin
            n_err++;
            $display("FAIL fips_verdict: got done/pass/timeout=%b, want 110", {a_done, a_pass, a_timeout});
        end
        n_vec++;
        if (a_pass_cnt !== 16'd1 || a_fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL fips_counts: got pass=%0d fail=%0d, want 1/0", a_pass_cnt, a_fail_cnt);
        end
        $display("test_fips: done=%0d pass=%0d pass_cnt=%0d", a_done, a_pass, a_pass_cnt);
    endtask

    task automatic test_mismatch;
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            int k;
            k = c - 21;
            b_in_valid  = (c < 16);
            b_in_expect = (c < 16) ? vec[c] : '0;
            if (k >= 0 && k < 16) b_dut_out = (k == 5) ? (vec[k] ^ 128'd1) : vec[k];
            else                  b_dut_out = '0;
            tick();
            if (c == 35) begin
                n_vec++;
                if (b_done !== 1'b0 || b_pass_cnt !== 16'd14) begin
                    n_err++;
                    $display("FAIL mm_before_last: got done=%0d pass_cnt=%0d, want 0/14", b_done, b_pass_cnt);
                end
            end
        end
        n_vec++;
        if (b_pass_cnt !== 16'd15 || b_fail_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL mm_counts: got pass=%0d fail=%0d, want 15/1", b_pass_cnt, b_fail_cnt);
        end
        n_vec++;
        if (b_ffi !== 16'd5) begin
            n_err++;
            $display("FAIL mm_first_idx: got %0d, want 5", b_ffi);
        end
        n_vec++;
        if (b_ffd !== (vec[5] ^ 128'd1)) begin
            n_err++;
            $display("FAIL mm_first_data: got %h, want %h", b_ffd, vec[5] ^ 128'd1);
        end
        n_vec++;
        if ({b_done, b_pass, b_timeout} !== 3'b100) begin
            n_err++;
            $display("FAIL mm_verdict: got done/pass/timeout=%b, want 100", {b_done, b_pass, b_timeout});
        end
        $display("test_mismatch: pass_cnt=%0d fail_cnt=%0d idx=%0d", b_pass_cnt, b_fail_cnt, b_ffi);
    endtask

    // Continues from test_mismatch: u_b is in DONE with 15/1.
    task automatic test_after_done;
        for (int c = 0; c < 30; c++) begin
            b_in_valid  = 1'b1;
            b_in_expect = vec[c % 16];
            b_dut_out   = ~vec[c % 16];
            tick();
            n_vec++;
            if ({b_done, b_pass, b_timeout} !== 3'b100) begin
                n_err++;
                $display("FAIL hold_flags cycle %0d: got %b, want 100", c, {b_done, b_pass, b_timeout});
            end
        end
        n_vec++;
        if (b_pass_cnt !== 16'd15 || b_fail_cnt !== 16'd1 || b_ffi !== 16'd5) begin
            n_err++;
            $display("FAIL hold_counts: got pass=%0d fail=%0d idx=%0d, want 15/1/5", b_pass_cnt, b_fail_cnt, b_ffi);
        end
        b_in_valid = 1'b0;
        $display("test_after_done: pass_cnt=%0d fail_cnt=%0d", b_pass_cnt, b_fail_cnt);
    endtask

    task automatic test_timeout;
        do_reset();
        for (int c = 0; c <= 87; c++) begin
            b_in_valid  = (c < 3);
            b_in_expect = (c < 3) ? vec[c] : '0;
            b_dut_out   = (c >= 21 && c < 24) ? vec[c-21] : '0;
            tick();
            if (c == 86) begin
                n_vec++;
                if ({b_done, b_timeout} !== 2'b00) begin
                    n_err++;
                    $display("FAIL tout_early: got done/timeout=%b, want 00", {b_done, b_timeout});
                end
            end
        end
        n_vec++;
        if ({b_done, b_pass, b_timeout} !== 3'b101) begin
            n_err++;
            $display("FAIL tout_verdict: got done/pass/timeout=%b, want 101", {b_done, b_pass, b_timeout});
        end
        n_vec++;
        if (b_pass_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL tout_pass_cnt: got %0d, want 3", b_pass_cnt);
        end
        $display("test_timeout: timeout=%0d pass_cnt=%0d", b_timeout, b_pass_cnt);
    endtask

    task automatic test_reset_midstream;
        do_reset();
        // 15 issues; after edge 25 five have compared and ten are in flight.
        for (int c = 0; c <= 25; c++) begin
            b_in_valid  = (c < 15);
            b_in_expect = (c < 15) ? vec[c] : '0;
            b_dut_out   = (c >= 21) ? vec[c-21] : '0;
            tick();
        end
        n_vec++;
        if (b_pass_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL mid_pre_reset: got pass_cnt=%0d, want 5", b_pass_cnt);
        end
        b_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({b_pass_cnt, b_fail_cnt, b_done, b_pass, b_timeout} !== '0) begin
            n_err++;
            $display("FAIL mid_async_clear: got pass=%0d fail=%0d flags=%b, want all 0",
                     b_pass_cnt, b_fail_cnt, {b_done, b_pass, b_timeout});
        end
        tick();
        tick();
        rst_n = 1'b1;
        // The core keeps producing stale results; none may be compared.
        for (int c = 0; c < 30; c++) begin
            b_dut_out = vec[(c + 5) % 16];
            tick();
        end
        n_vec++;
        if ({b_pass_cnt, b_fail_cnt} !== '0 || b_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_stale: got pass=%0d fail=%0d done=%0d, want 0/0/0", b_pass_cnt, b_fail_cnt, b_done);
        end
        // Fresh clean run.
        for (int c = 0; c <= 36; c++) begin
            b_in_valid  = (c < 16);
            b_in_expect = (c < 16) ? vec[c] : '0;
            b_dut_out   = (c >= 21) ? vec[c-21] : '0;
            tick();
        end
        n_vec++;
        if ({b_done, b_pass} !== 2'b11 || b_pass_cnt !== 16'd16 || b_fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_fresh_run: got done/pass=%b pass=%0d fail=%0d, want 11/16/0",
                     {b_done, b_pass}, b_pass_cnt, b_fail_cnt);
        end
        b_in_valid = 1'b0;
        $display("test_reset_midstream: fresh pass_cnt=%0d pass=%0d", b_pass_cnt, b_pass);
    endtask

    task automatic test_latency1;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            c_in_valid  = (c <= 5);
            c_in_expect = vec[c];
            c_dut_out   = (c >= 1) ? vec[c-1] : '0;
            tick();
            if (c <= 4) begin
                n_vec++;
                if (c_pass_cnt !== 16'(c) || c_done !== (c == 4)) begin
                    n_err++;
                    $display("FAIL lat1_edge%0d: got pass_cnt=%0d done=%0d, want %0d/%0d",
                             c, c_pass_cnt, c_done, c, (c == 4));
                end
            end
        end
        n_vec++;
        if ({c_done, c_pass, c_timeout} !== 3'b110 || c_pass_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL lat1_final: got flags=%b pass_cnt=%0d, want 110/4", {c_done, c_pass, c_timeout}, c_pass_cnt);
        end
        c_in_valid = 1'b0;
        $display("test_latency1: pass_cnt=%0d done=%0d", c_pass_cnt, c_done);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vec[i] = {32'hA5A50000 | 32'(i), ~32'(i), 32'h0F1E2D3C ^ 32'(i * 7), 32'(i * 32'h01010101)};
        end
        test_reset();
        test_fips();
        test_mismatch();
        test_after_done();
        test_timeout();
        test_reset_midstream();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/aes_stream_checker.md
Name: aes_stream_checker

Overview:
- Synthesisable, parametrised self-checking monitor for pipelined AES cores (aes_128 and wider-key variants); sits beside the core in benches and FPGA bring-up builds.
- Accepts an expected ciphertext each time a block is issued to the core, delays it by the core latency, and compares it with the core output.
- Accumulates pass/fail counts, captures the first mismatch, detects a stalled stream via a watchdog, and reports a final verdict after NUM_VEC comparisons.

Parameters:
- DATA_W, 128, width of the compared data (block width).
- LATENCY, 21, clocks from a block issued to the core until its result is valid on dut_out; must be >= 1.
- NUM_VEC, 16, number of comparisons that completes a run.
- CNT_W, 16, width of the count and index outputs; counters saturate at 2^CNT_W-1.
- TIMEOUT, 1024, idle clocks in RUN with no in_valid and no comparison before a timeout is declared.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a block was issued to the core on this edge.
- in_expect  input  DATA_W  expected core output for that block.
- dut_out  input  DATA_W  core output.
- pass_cnt  output  CNT_W  number of matching comparisons.
- fail_cnt  output  CNT_W  number of mismatching comparisons.
- first_fail_idx  output  CNT_W  comparison index (0-based) of the first mismatch.
- first_fail_data  output  DATA_W  dut_out value captured at the first mismatch.
- done  output  1  run finished (complete or timeout).
- pass  output  1  done with fail_cnt==0 and no timeout.
- timeout  output  1  watchdog fired.

Behaviour:
- Reset (async assert, sync release): all outputs, counters, the delay line and the FSM state clear to 0. Reset mid-run discards every in-flight entry.
- Delay line: LATENCY stages holding {valid, expect}. A valid/expect pair sampled at edge T is compared against dut_out sampled at edge T+LATENCY. Issues on consecutive clocks are supported with no bubbles.
- Comparison: on a compare edge, equality (all DATA_W bits) increments pass_cnt; inequality increments fail_cnt. On the first mismatch only, first_fail_idx takes the current comparison index and first_fail_data takes dut_out.
- Comparison index: chk_cnt, an internal counter that increments on every compare.
- FSM states: IDLE, RUN, DONE, TOUT.
  - IDLE -> RUN: on the first in_valid.
  - RUN -> DONE: on the compare edge where chk_cnt reaches NUM_VEC. On that edge done=1 and pass=(fail_cnt_next==0).
  - RUN -> TOUT: the idle counter reaches TIMEOUT. The idle counter clears on any in_valid or compare. On entry to TOUT, done=1, timeout=1, pass=0.
  - DONE and TOUT: terminal until reset. in_valid is ignored, the delay line is frozen, and counters hold.
- Simultaneous in_valid and compare on the same edge: both are processed.
- in_valid pairs issued beyond NUM_VEC may still be in flight when DONE is reached; they are dropped.
- Counters saturate and never wrap.

Optional Feature:
- Macro: AES_CHK_DISPLAY_EN.
- Defined: simulation messages are emitted.
  - Each mismatch prints the index, expected value and actual value.
  - On entry to DONE, prints "Good." if pass, else "Bad." with fail_cnt, then calls $finish.
  - On entry to TOUT, prints "Timeout." then calls $finish.
- Undefined: no system tasks are compiled and the block is purely synthesisable. Port behaviour is identical either way.

Decomposition:
- Package aes_chk_pkg: FSM state typedef (IDLE/RUN/DONE/TOUT) and the default AES_BLOCK_W=128 constant.
- Sub-module aes_chk_delay_line (params W, DEPTH): valid+data shift register with a freeze input; instanced once with W=DATA_W.

Test Plan:
- FIPS-197 AES-128 (key 000102..0f, pt 00112233..ff), NUM_VEC=1: expect 69c4e0d86a7b0430d8cdb78070b4c55a issued at T, matching dut_out at T+21 -> done=1, pass=1, pass_cnt=1 on edge T+21.
- 16 back-to-back vectors, vector 5 corrupted (bit 0 flipped) -> pass_cnt=15, fail_cnt=1, first_fail_idx=5, first_fail_data=corrupted value, pass=0.
- 3 vectors then stop issuing with NUM_VEC=16, TIMEOUT=64 -> timeout=1, done=1, pass=0 exactly 64 idle clocks after the last compare.
- rst_n pulsed low mid-stream with 10 entries in flight -> all outputs 0 immediately; no compares occur from pre-reset issues; a subsequent fresh run passes.
- LATENCY=1, NUM_VEC=4, issue every clock -> comparisons on 4 consecutive edges, done on the 4th.
- in_valid held high after DONE -> counters unchanged, done/pass stable.
